// File: rtl/fetch_inst_buf_pkg.sv
// Shared constants and helpers for the fetch instruction buffer.
//   INST_W       : instruction width
//   FETCH_SLOTS  : instructions per fetch packet
//   PC_W_DEFAULT : default PC width
//   NOP_INST     : canonical NOP encoding, used to fill unused slots
package fetch_inst_buf_pkg;

  localparam int unsigned INST_W       = 32;
  localparam int unsigned FETCH_SLOTS  = 2;
  localparam int unsigned PC_W_DEFAULT = 64;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // Number of valid slots in a 2-slot fetch mask.
  function automatic logic [1:0] popcount2(input logic [1:0] mask);
    return {mask[0] & mask[1], mask[0] ^ mask[1]};
  endfunction

endpackage

// File: rtl/fetch_inst_buf_ram.sv
// DEPTH x {inst, pc} register array for the fetch instruction buffer.
// Two write ports (the top drives tail and tail+1) and two combinational
// read ports (head and head+1). Storage is not reset.
//   clock                        : core clock
//   i_we0/i_waddr0/i_winst0/i_wpc0 : write port 0
//   i_we1/i_waddr1/i_winst1/i_wpc1 : write port 1 (never same address as port 0)
//   i_raddr0/o_rinst0/o_rpc0     : read port 0
//   i_raddr1/o_rinst1/o_rpc1     : read port 1
module fetch_inst_buf_ram
  import fetch_inst_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_we0,
  input  logic [AW-1:0]     i_waddr0,
  input  logic [INST_W-1:0] i_winst0,
  input  logic [PC_W-1:0]   i_wpc0,
  input  logic              i_we1,
  input  logic [AW-1:0]     i_waddr1,
  input  logic [INST_W-1:0] i_winst1,
  input  logic [PC_W-1:0]   i_wpc1,
  input  logic [AW-1:0]     i_raddr0,
  output logic [INST_W-1:0] o_rinst0,
  output logic [PC_W-1:0]   o_rpc0,
  input  logic [AW-1:0]     i_raddr1,
  output logic [INST_W-1:0] o_rinst1,
  output logic [PC_W-1:0]   o_rpc1
);

  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we0) begin
      r_inst[i_waddr0] <= i_winst0;
      r_pc[i_waddr0]   <= i_wpc0;
    end
    if (i_we1) begin
      r_inst[i_waddr1] <= i_winst1;
      r_pc[i_waddr1]   <= i_wpc1;
    end
  end

  assign o_rinst0 = r_inst[i_raddr0];
  assign o_rpc0   = r_pc[i_raddr0];
  assign o_rinst1 = r_inst[i_raddr1];
  assign o_rpc1   = r_pc[i_raddr1];

endmodule

// File: rtl/fetch_inst_buf.sv
// Instruction buffer between fetch and the two decode ways. Compacts valid
// fetch slots into a circular queue and presents the two oldest entries.
// DEPTH must be a power of two, at least 4.
//   clock, reset        : clock, asynchronous active-high reset
//   flush_i             : discard all buffered instructions
//   fetch_valid_i/mask_i/inst_i/pc_i : 2-slot fetch packet
//   fetch_ready_o       : room for a full packet
//   dec_stall_i         : decode cannot accept this cycle
//   way0_*/way1_*       : oldest / second-oldest entry
//   pipe_load_decode_o  : decode registers load (and buffer pops) this cycle
module fetch_inst_buf
  import fetch_inst_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = PC_W_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  input  logic [FETCH_SLOTS-1:0]        fetch_mask_i,
  input  logic [FETCH_SLOTS*INST_W-1:0] fetch_inst_i,
  input  logic [PC_W-1:0]               fetch_pc_i,
  output logic                          fetch_ready_o,
  input  logic                          dec_stall_i,
  output logic                          way0_valid_o,
  output logic [INST_W-1:0]             way0_inst_o,
  output logic [PC_W-1:0]               way0_pc_o,
  output logic                          way1_valid_o,
  output logic [INST_W-1:0]             way1_inst_o,
  output logic [PC_W-1:0]               way1_pc_o,
  output logic                          pipe_load_decode_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_head_d, w_tail_d;
  logic [CW-1:0] w_count_d;

  logic          w_push, w_pop;
  logic [CW-1:0] w_push_n, w_pop_n;
  logic [INST_W-1:0] w_slot0_inst, w_slot1_inst;
  logic [PC_W-1:0]   w_slot1_pc;

  assign w_slot0_inst = fetch_inst_i[INST_W-1:0];
  assign w_slot1_inst = fetch_inst_i[2*INST_W-1:INST_W];
  assign w_slot1_pc   = fetch_pc_i + PC_W'(4);

  // Ready looks at the current count only; a same-cycle pop does not help.
  assign fetch_ready_o = (r_count <= CW'(DEPTH - 2));
  assign way0_valid_o  = (r_count != '0);
  assign way1_valid_o  = (r_count >= CW'(2));

  assign w_push   = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign w_push_n = w_push ? CW'(popcount2(fetch_mask_i)) : '0;

  // Decode takes both valid ways or neither.
  assign pipe_load_decode_o = way0_valid_o & ~dec_stall_i & ~flush_i;
  assign w_pop   = pipe_load_decode_o;
  assign w_pop_n = w_pop ? (way1_valid_o ? CW'(2) : CW'(1)) : '0;

  always_comb begin
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_count_d = r_count;
    if (flush_i) begin
      w_head_d  = '0;
      w_tail_d  = '0;
      w_count_d = '0;
    end else begin
      w_head_d  = r_head + w_pop_n[AW-1:0];
      w_tail_d  = r_tail + w_push_n[AW-1:0];
      w_count_d = r_count + w_push_n - w_pop_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
    end
  end

  // Port 0 takes the first valid slot (compaction); port 1 only when both valid.
  logic w_we0, w_we1;
  logic [INST_W-1:0] w_winst0;
  logic [PC_W-1:0]   w_wpc0;

  assign w_we0    = w_push & (|fetch_mask_i);
  assign w_we1    = w_push & (&fetch_mask_i);
  assign w_winst0 = fetch_mask_i[0] ? w_slot0_inst : w_slot1_inst;
  assign w_wpc0   = fetch_mask_i[0] ? fetch_pc_i : w_slot1_pc;

  fetch_inst_buf_ram #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_ram (
    .clock    (clock),
    .i_we0    (w_we0),
    .i_waddr0 (r_tail),
    .i_winst0 (w_winst0),
    .i_wpc0   (w_wpc0),
    .i_we1    (w_we1),
    .i_waddr1 (r_tail + AW'(1)),
    .i_winst1 (w_slot1_inst),
    .i_wpc1   (w_slot1_pc),
    .i_raddr0 (r_head),
    .o_rinst0 (way0_inst_o),
    .o_rpc0   (way0_pc_o),
    .i_raddr1 (r_head + AW'(1)),
    .o_rinst1 (way1_inst_o),
    .o_rpc1   (way1_pc_o)
  );

  a_count_bound : assert property (@(posedge clock) disable iff (reset)
    r_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_inst_buf.sv
module tb_fetch_inst_buf;
  import fetch_inst_buf_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush_i;
  logic            fetch_valid_i;
  logic [1:0]      fetch_mask_i;
  logic [63:0]     fetch_inst_i;
  logic [PC_W-1:0] fetch_pc_i;
  logic            fetch_ready_o;
  logic            dec_stall_i;
  logic            way0_valid_o;
  logic [31:0]     way0_inst_o;
  logic [PC_W-1:0] way0_pc_o;
  logic            way1_valid_o;
  logic [31:0]     way1_inst_o;
  logic [PC_W-1:0] way1_pc_o;
  logic            pipe_load_decode_o;

  fetch_inst_buf #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_mask_i       (fetch_mask_i),
    .fetch_inst_i       (fetch_inst_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_ready_o      (fetch_ready_o),
    .dec_stall_i        (dec_stall_i),
    .way0_valid_o       (way0_valid_o),
    .way0_inst_o        (way0_inst_o),
    .way0_pc_o          (way0_pc_o),
    .way1_valid_o       (way1_valid_o),
    .way1_inst_o        (way1_inst_o),
    .way1_pc_o          (way1_pc_o),
    .pipe_load_decode_o (pipe_load_decode_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t model[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge: drive one cycle, check outputs against the queue
  // model, update the model with what the coming edge must do.
  task automatic step(input logic v, input logic [1:0] m, input logic [63:0] insts,
                      input logic [PC_W-1:0] pc, input logic st, input logic fl);
    int   sz;
    int   npop;
    ent_t e;
    fetch_valid_i = v;
    fetch_mask_i  = m;
    fetch_inst_i  = insts;
    fetch_pc_i    = pc;
    dec_stall_i   = st;
    flush_i       = fl;
    #1;
    sz = model.size();
    check_eq("ready", 64'(fetch_ready_o), 64'(sz <= DEPTH - 2));
    check_eq("way0_valid", 64'(way0_valid_o), 64'(sz >= 1));
    check_eq("way1_valid", 64'(way1_valid_o), 64'(sz >= 2));
    check_eq("pipe_load", 64'(pipe_load_decode_o), 64'(sz >= 1 && !st && !fl));
    if (sz >= 1) begin
      check_eq("way0_inst", 64'(way0_inst_o), 64'(model[0].inst));
      check_eq("way0_pc", way0_pc_o, model[0].pc);
    end
    if (sz >= 2) begin
      check_eq("way1_inst", 64'(way1_inst_o), 64'(model[1].inst));
      check_eq("way1_pc", way1_pc_o, model[1].pc);
    end
    if (fl) begin
      model.delete();
    end else begin
      npop = (sz >= 1 && !st) ? ((sz >= 2) ? 2 : 1) : 0;
      for (int i = 0; i < npop; i++) void'(model.pop_front());
      if (v && sz <= DEPTH - 2) begin
        if (m[0]) begin
          e.inst = insts[31:0];
          e.pc   = pc;
          model.push_back(e);
        end
        if (m[1]) begin
          e.inst = insts[63:32];
          e.pc   = pc + 4;
          model.push_back(e);
        end
      end
    end
    @(negedge clock);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; effect must be immediate.
  task automatic pulse_reset();
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    reset         = 1'b1;
    #1;
    check_eq("rst_ready", 64'(fetch_ready_o), 64'(1));
    check_eq("rst_way0_valid", 64'(way0_valid_o), 64'(0));
    check_eq("rst_way1_valid", 64'(way1_valid_o), 64'(0));
    check_eq("rst_pipe_load", 64'(pipe_load_decode_o), 64'(0));
    model.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [PC_W-1:0] pc_seq;
  int              stall_pct;

  initial begin
    reset         = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_mask_i  = 2'b00;
    fetch_inst_i  = '0;
    fetch_pc_i    = '0;
    dec_stall_i   = 1'b0;
    repeat (2) @(negedge clock);
    pulse_reset();

    // Full packet, then pop both.
    step(1'b1, 2'b11, 64'hBBBB_BBBB_AAAA_AAAA, 64'h1000, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    // Slot1 only.
    step(1'b1, 2'b10, {32'hCCCC_CCCC, NOP_INST}, 64'h2000, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    // Fill under stall; 5th packet dropped.
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'b11, rnd64(), 64'h3000 + 64'(8 * i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    // Steady push 2 / pop 2 across the wrap.
    step(1'b1, 2'b11, rnd64(), 64'h4000, 1'b1, 1'b0);
    for (int i = 1; i < 11; i++)
      step(1'b1, 2'b11, rnd64(), 64'h4000 + 64'(8 * i), 1'b0, 1'b0);
    // Build count 5 then flush alongside a packet.
    step(1'b1, 2'b11, rnd64(), 64'h5000, 1'b1, 1'b1);
    step(1'b1, 2'b11, rnd64(), 64'h5000, 1'b1, 1'b0);
    step(1'b1, 2'b11, rnd64(), 64'h5008, 1'b1, 1'b0);
    step(1'b1, 2'b01, rnd64(), 64'h5010, 1'b1, 1'b0);
    step(1'b1, 2'b11, rnd64(), 64'h5018, 1'b1, 1'b1);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    // Reset with count 3, then first push after reset.
    step(1'b1, 2'b11, rnd64(), 64'h6000, 1'b1, 1'b0);
    step(1'b1, 2'b01, rnd64(), 64'h6008, 1'b1, 1'b0);
    pulse_reset();
    step(1'b1, 2'b10, rnd64(), 64'h7000, 1'b1, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);

    // Randomized traffic in phases of differing decode pressure.
    pc_seq    = 64'h8000;
    stall_pct = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) stall_pct = int'($urandom_range(0, 90));
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), rnd64(), pc_seq,
             $urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < 3);
        pc_seq = pc_seq + 8;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
